// File: rtl/cake_game_pkg.sv
// Shared types and constants for the cake recipe minigame.
// State codes, recipe ROM contents and default timeouts.
package cake_game_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_WAIT  = 4'd2,
    S_CHECK = 4'd3,
    S_FIM   = 4'd4
  } state_e;

  localparam int DEF_STEPS    = 7;
  localparam int DEF_T_NORMAL = 3000;
  localparam int DEF_T_HARD   = 1500;

  // Step 0 sits in the low three bits.
  localparam logic [20:0] RECIPE_NORMAL = {
    3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1
  };
  localparam logic [20:0] RECIPE_HARD = {
    3'd4, 3'd5, 3'd2, 3'd7, 3'd1, 3'd6, 3'd3
  };

  function automatic logic [2:0] recipe(
    input logic       hard,
    input logic [2:0] step
  );
    logic [20:0] rom;
    logic [20:0] sh;
    rom = hard ? RECIPE_HARD : RECIPE_NORMAL;
    sh  = rom >> (3 * int'(step));
    return (step > 3'd6) ? 3'd0 : sh[2:0];
  endfunction

  function automatic logic [6:0] onehot(input logic [2:0] code);
    logic [6:0] r;
    r = '0;
    if (code != 3'd0) r[code - 3'd1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cake_game_timer.sv
// Loadable down-counter for the per-step timeout.
// Stops at zero; zero flag is decoded from the count register.
module cake_game_timer #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = value;
    else if (en && count_q != '0)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/cake_game.sv
// Cake recipe reaction minigame: FSM, press-edge detect and scoring.
// Define CAKE_GAME_STRICT_EN to end the game on the first miss.
module cake_game
  import cake_game_pkg::*;
#(
  parameter int STEPS    = DEF_STEPS,
  parameter int T_NORMAL = DEF_T_NORMAL,
  parameter int T_HARD   = DEF_T_HARD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       dificuldade,
  input  logic [6:0] botoes,
  output logic [3:0] estado,
  output logic [6:0] jogadas,
  output logic [2:0] leds,
  output logic [2:0] pontuacao,
  output logic       pronto
);

  localparam int TW = $clog2(T_NORMAL + 1);
  localparam logic [2:0] LAST = 3'(STEPS - 1);
  localparam logic [TW-1:0] TV_NORMAL = TW'(T_NORMAL);
  localparam logic [TW-1:0] TV_HARD   = TW'(T_HARD);

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [2:0] score_q, score_d;
  logic [6:0] jogadas_q, jogadas_d;
  logic       diff_q, diff_d;
  logic       hit_q, hit_d;
  logic [6:0] prev_botoes_q;

  logic       press;
  logic [2:0] code;
  logic       t_load;
  logic       t_en;
  logic       t_zero;

  // Sampled through reset too, so a button held across reset is not a press.
  always_ff @(posedge clock) begin
    prev_botoes_q <= botoes;
  end

  assign press  = (botoes != '0) && (prev_botoes_q == '0);
  assign code   = recipe(diff_q, step_q);
  assign t_load = (state_q == S_LOAD);
  assign t_en   = (state_q == S_WAIT) && !press && !t_zero;

  cake_game_timer #(
    .W (TW)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (t_load),
    .value (diff_q ? TV_HARD : TV_NORMAL),
    .en    (t_en),
    .zero  (t_zero)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    score_d   = score_q;
    jogadas_d = jogadas_q;
    diff_d    = diff_q;
    hit_d     = hit_q;
    unique case (state_q)
      S_IDLE, S_FIM: begin
        if (jogar) begin
          state_d   = S_LOAD;
          step_d    = '0;
          score_d   = '0;
          jogadas_d = '0;
          diff_d    = dificuldade;
        end
      end
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        if (press) begin
          jogadas_d = botoes;
          hit_d     = (botoes == onehot(code));
          state_d   = S_CHECK;
        end else if (t_zero) begin
          hit_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hit_q && score_q != 3'd7)
          score_d = score_q + 3'd1;
`ifdef CAKE_GAME_STRICT_EN
        if (!hit_q || step_q == LAST)
          state_d = S_FIM;
`else
        if (step_q == LAST)
          state_d = S_FIM;
`endif
        else begin
          step_d  = step_q + 3'd1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      score_q   <= '0;
      jogadas_q <= '0;
      diff_q    <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      score_q   <= score_d;
      jogadas_q <= jogadas_d;
      diff_q    <= diff_d;
      hit_q     <= hit_d;
    end
  end

  assign estado    = state_q;
  assign jogadas   = jogadas_q;
  assign pontuacao = score_q;
  assign pronto    = (state_q == S_FIM);
  assign leds      = (state_q == S_WAIT) ? code : 3'd0;

endmodule

// File: tb/tb_cake_game.sv
// Self-checking bench for cake_game with short timeouts.
// Expected ingredient codes flow through a scoreboard queue.
module tb_cake_game;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       jogar = 1'b0;
  logic       dificuldade = 1'b0;
  logic [6:0] botoes = '0;
  logic [3:0] estado;
  logic [6:0] jogadas;
  logic [2:0] leds;
  logic [2:0] pontuacao;
  logic       pronto;

  int errors = 0;
  int checks = 0;
  logic [2:0] sb[$];

  cake_game #(
    .STEPS    (7),
    .T_NORMAL (10),
    .T_HARD   (5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .jogar       (jogar),
    .dificuldade (dificuldade),
    .botoes      (botoes),
    .estado      (estado),
    .jogadas     (jogadas),
    .leds        (leds),
    .pontuacao   (pontuacao),
    .pronto      (pronto)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input string nm);
    int n = 0;
    while (estado !== s && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (estado !== s) begin
      errors++;
      $display("FAIL %s wait: estado=%0d want %0d", nm, estado, s);
    end
  endtask

  task automatic start(input logic d);
    jogar = 1'b1;
    dificuldade = d;
    tick();
    jogar = 1'b0;
    checks++;
    if (estado !== 4'd1 || pontuacao !== 3'd0 || jogadas !== 7'd0) begin
      errors++;
      $display("FAIL start: estado=%0d pont=%0d jog=%b want 1/0/0",
               estado, pontuacao, jogadas);
    end
  endtask

  // One step: pops the expected code when WAIT shows up, then
  // presses btn (or waits out the timer when btn is zero).
  task automatic play_step(input logic [6:0] btn, input int wlen,
                           input logic [2:0] exp_score);
    logic [2:0] exp;
    int n;
    wait_state(4'd2, "step");
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: leds=%0d with no expected code", leds);
    end else begin
      exp = sb.pop_front();
      if (leds !== exp) begin
        errors++;
        $display("FAIL leds: got %0d want %0d", leds, exp);
      end
    end
    if (btn != '0) begin
      botoes = btn;
      tick();
      botoes = '0;
    end else begin
      n = 1;
      while (estado === 4'd2 && n < 40) begin
        tick();
        if (estado === 4'd2) n++;
      end
      checks++;
      if (n != wlen) begin
        errors++;
        $display("FAIL wait_len: got %0d want %0d", n, wlen);
      end
    end
    checks++;
    if (estado !== 4'd3) begin
      errors++;
      $display("FAIL check_state: estado=%0d want 3", estado);
    end
    tick();
    checks++;
    if (pontuacao !== exp_score) begin
      errors++;
      $display("FAIL score: got %0d want %0d", pontuacao, exp_score);
    end
  endtask

  task automatic check_fim(input logic [2:0] sc, input logic [6:0] jg);
    checks++;
    if (estado !== 4'd4 || pronto !== 1'b1 || pontuacao !== sc ||
        jogadas !== jg || leds !== 3'd0) begin
      errors++;
      $display("FAIL fim: est=%0d pr=%b pont=%0d jog=%b leds=%0d want 4/1/%0d/%b/0",
               estado, pronto, pontuacao, jogadas, leds, sc, jg);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (estado !== 0 || jogadas !== 0 || leds !== 0 ||
        pontuacao !== 0 || pronto !== 0) begin
      errors++;
      $display("FAIL reset: est=%0d jog=%b leds=%0d pont=%0d pr=%b want zeros",
               estado, jogadas, leds, pontuacao, pronto);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_perfect_normal();
    start(1'b0);
    for (int k = 0; k < 7; k++) sb.push_back(3'(k + 1));
    for (int k = 0; k < 7; k++)
      play_step(7'(1 << k), 0, 3'(k + 1));
    check_fim(3'd7, 7'b1000000);
  endtask

  task automatic test_hard_timeouts();
    logic [2:0] hard_seq[7] = '{3, 6, 1, 7, 2, 5, 4};
    start(1'b1);
    for (int k = 0; k < 7; k++) sb.push_back(hard_seq[k]);
    for (int k = 0; k < 7; k++) play_step('0, 6, 3'd0);
    check_fim(3'd0, 7'd0);
  endtask

  task automatic test_wrong_multi();
    start(1'b0);
    for (int k = 0; k < 7; k++) sb.push_back(3'(k + 1));
`ifdef CAKE_GAME_STRICT_EN
    play_step(7'b0000010, 0, 3'd0);
    sb.delete();
    check_fim(3'd0, 7'b0000010);
`else
    play_step(7'b0000010, 0, 3'd0);
    play_step(7'b0000011, 0, 3'd0);
    for (int k = 2; k < 7; k++)
      play_step(7'(1 << k), 0, 3'(k - 1));
    check_fim(3'd5, 7'b1000000);
`endif
  endtask

  task automatic test_held_and_reset();
    start(1'b0);
    sb.push_back(3'd1);
    sb.push_back(3'd2);
    wait_state(4'd2, "held0");
    void'(sb.pop_front());
    botoes = 7'b0000001;
    tick();
    tick();
    checks++;
    if (pontuacao !== 3'd1 || jogadas !== 7'b0000001) begin
      errors++;
      $display("FAIL held0: pont=%0d jog=%b want 1/0000001", pontuacao, jogadas);
    end
    play_step('0, 11, 3'd1);
    checks++;
    if (jogadas !== 7'b0000001) begin
      errors++;
      $display("FAIL held_capture: jog=%b want 0000001", jogadas);
    end
    botoes = '0;
    sb.push_back(3'd3);
    play_step(7'b0000100, 0, 3'd2);
    wait_state(4'd2, "step3");
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
    checks++;
    if (estado !== 4'd2 || leds !== 3'd4) begin
      errors++;
      $display("FAIL jogar_ignored: est=%0d leds=%0d want 2/4", estado, leds);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (estado !== 0 || jogadas !== 0 || leds !== 0 ||
        pontuacao !== 0 || pronto !== 0) begin
      errors++;
      $display("FAIL async_reset: est=%0d jog=%b leds=%0d pont=%0d pr=%b want zeros",
               estado, jogadas, leds, pontuacao, pronto);
    end
    tick();
    reset = 1'b0;
    tick();
    start(1'b0);
    sb.push_back(3'd1);
    play_step(7'b0000001, 0, 3'd1);
  endtask

  task automatic test_restart_fim();
    for (int k = 1; k < 7; k++) sb.push_back(3'(k + 1));
    for (int k = 1; k < 7; k++)
      play_step(7'(1 << k), 0, 3'(k + 1));
    check_fim(3'd7, 7'b1000000);
    start(1'b1);
    sb.push_back(3'd3);
    play_step(7'b0000100, 0, 3'd1);
  endtask

  initial begin
    test_reset();
    test_perfect_normal();
    test_hard_timeouts();
    test_wrong_multi();
    test_held_and_reset();
    test_restart_fim();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
